uart_cmd_rx: RTL and testbench
==============================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clock cycles per UART bit (12 MHz / 115200).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 20, inter-byte idle bit-times before the parser abandons a partial command.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port o_byte  output  8  last correctly framed received byte.
REQ-007 SHALL have port o_byte_valid  output  1  one-cycle pulse when o_byte updates.
REQ-008 SHALL have port o_frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-009 SHALL have port o_addr  output  8  register address of last accepted command.
REQ-010 SHALL have port o_data  output  16  data value of last accepted command.
REQ-011 SHALL have port o_wr  output  1  one-cycle pulse when o_addr/o_data update.
REQ-012 SHALL have port o_cksum_err  output  1  one-cycle pulse on command checksum mismatch.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-014 SHALL implement a bit FSM with states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 SHALL leave IDLE for START on a synchronized high-to-low transition.
REQ-016 In START, SHALL sample at CLKS_PER_BIT/2 cycles (integer division); low -> DATA, high -> IDLE with no output pulse (glitch reject).
REQ-017 In DATA, SHALL sample every CLKS_PER_BIT cycles, 8 bits, LSB first, then go to STOP.
REQ-018 In STOP, SHALL sample one bit later. High: load o_byte, pulse o_byte_valid the next cycle, return to IDLE. Low: pulse o_frame_err, discard byte, go to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL return to IDLE only after synchronized rx is high; it SHALL NOT detect a start edge while rx stays low.
REQ-020 SHALL implement a parser FSM with states P_SYNC, P_ADDR, P_DHI, P_DLO, P_CK, advancing one state per o_byte_valid.
REQ-021 P_SYNC SHALL advance only on byte 0xA5 and ignore all other bytes; 0xA5 in any later state is treated as data.
REQ-022 In P_CK, SHALL compare the byte with addr XOR dhi XOR dlo. Match: o_addr={addr}, o_data={dhi,dlo}, o_wr pulses the cycle after that o_byte_valid. Mismatch: o_cksum_err pulses the same cycle instead. Both cases return to P_SYNC.
REQ-023 o_addr/o_data SHALL hold their value between o_wr pulses and SHALL change only with o_wr.
REQ-024 o_frame_err SHALL force the parser to P_SYNC from any state.
REQ-025 Outside P_SYNC, an idle interval of TIMEOUT_BITS*CLKS_PER_BIT cycles since the last o_byte_valid SHALL force P_SYNC with no pulse. The timeout counter SHALL saturate, not wrap.
REQ-026 When a timeout and o_byte_valid occur in the same cycle, the byte SHALL take priority and the timeout counter SHALL clear.
REQ-027 Back-to-back frames with no idle bits SHALL be received without loss; the bit FSM SHALL be in IDLE before the next start edge at mid-stop + CLKS_PER_BIT/2.
REQ-028 Bit and timeout counters SHALL be sized from the parameters via $clog2 and SHALL NOT overflow at the default values.

Reset
REQ-029 While reset is high, SHALL set both FSMs to IDLE / P_SYNC and both synchronizer flops to 1.
REQ-030 While reset is high, SHALL set o_byte=0x00, o_addr=0x00, o_data=0x0000, and all pulse outputs to 0.
REQ-031 Reset mid-byte or mid-command SHALL discard partial data; no pulse SHALL appear after release until a complete new frame or command is received.

Verification
REQ-032 Send 0x55 at 104 clk/bit -> exactly one o_byte_valid, o_byte=0x55, no o_frame_err.
REQ-033 Send bytes A5 01 00 96 97 -> one o_wr, o_addr=0x01, o_data=0x0096, five o_byte_valid pulses.
REQ-034 Send A5 02 00 0A 00 -> o_cksum_err pulse, no o_wr, o_addr/o_data unchanged.
REQ-035 Send 0x3C with stop bit held low for 3 bit-times, then A5 01 00 4B 4A -> o_frame_err once, no byte_valid for 0x3C, then o_wr with o_data=0x004B.
REQ-036 Drive a 40-cycle low glitch on rx -> no pulses, FSM back in IDLE. Then send A5 01, idle 21 bit-times, send 00 96 97 -> no o_wr (timeout).
REQ-037 Assert reset after the 3rd data bit of the 2nd byte of a command -> all outputs at reset values. A following full command is then accepted normally.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver feeding an A5-framed {addr, data_hi, data_lo, checksum} command parser
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    output logic        o_frame_err,
    output logic [7:0]  o_addr,
    output logic [15:0] o_data,
    output logic        o_wr,
    output logic        o_cksum_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW = $clog2(TLIM + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMAX = TW'(TLIM);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} bit_state_t;
    typedef enum logic [2:0] {P_SYNC, P_ADDR, P_DHI, P_DLO, P_CK} parse_state_t;

    bit_state_t   bs, bs_n;
    parse_state_t ps, ps_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [TW-1:0] tcnt;
    logic [7:0]    addr, dhi, dlo;
    logic          half_tick, full_tick, stop_tick, cmd_done, cksum_ok;

    assign half_tick   = bs == START && cnt == HALF;
    assign full_tick   = cnt == FULL;
    assign stop_tick   = bs == STOP && full_tick;
    assign cmd_done    = o_byte_valid && ps == P_CK;
    assign cksum_ok    = o_byte == (addr ^ dhi ^ dlo);
    assign o_cksum_err = cmd_done && !cksum_ok;

    // two-flop synchronizer, idle-high so reset never looks like a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) {rx_s, rx_m} <= 2'b11;
        else {rx_s, rx_m} <= {rx_m, rx};
    end

    // bit FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bs <= IDLE;
        else bs <= bs_n;
    end

    // bit FSM next state: mid-bit sampling, glitch reject, wait for line high after a framing error
    always_comb begin
        bs_n = bs;
        case (bs)
            IDLE:      bs_n = rx_s ? IDLE : START;
            START:     bs_n = half_tick ? (rx_s ? IDLE : DATA) : START;
            DATA:      bs_n = (full_tick && bit_idx == 3'd7) ? STOP : DATA;
            STOP:      bs_n = full_tick ? (rx_s ? IDLE : WAIT_HIGH) : STOP;
            WAIT_HIGH: bs_n = rx_s ? IDLE : WAIT_HIGH;
            default:   bs_n = IDLE;
        endcase
    end

    // bit timing counter, LSB-first shifter and registered byte / framing-error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            cnt          <= (bs_n != bs || full_tick) ? '0 : cnt + CW'(1);
            bit_idx      <= bs != DATA ? '0 : full_tick ? bit_idx + 3'd1 : bit_idx;
            if (bs == DATA && full_tick) shreg <= {rx_s, shreg[7:1]};
            if (stop_tick && rx_s) o_byte <= shreg;
            o_byte_valid <= stop_tick && rx_s;
            o_frame_err  <= stop_tick && !rx_s;
        end
    end

    // parser FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ps <= P_SYNC;
        else ps <= ps_n;
    end

    // parser next state: framing error aborts, a new byte outranks the idle timeout
    always_comb begin
        ps_n = o_frame_err ? P_SYNC
             : o_byte_valid ? (ps == P_SYNC ? (o_byte == 8'hA5 ? P_ADDR : P_SYNC)
                             : ps == P_CK ? P_SYNC : parse_state_t'(ps + 3'd1))
             : tcnt == TMAX ? P_SYNC : ps;
    end

    // field capture, saturating inter-byte timeout and command write-out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt   <= '0;
            addr   <= '0;
            dhi    <= '0;
            dlo    <= '0;
            o_addr <= '0;
            o_data <= '0;
            o_wr   <= 1'b0;
        end else begin
            tcnt <= o_byte_valid ? '0 : tcnt == TMAX ? tcnt : tcnt + TW'(1);
            if (o_byte_valid && ps == P_ADDR) addr <= o_byte;
            if (o_byte_valid && ps == P_DHI) dhi <= o_byte;
            if (o_byte_valid && ps == P_DLO) dlo <= o_byte;
            if (cmd_done && cksum_ok) begin
                o_addr <= addr;
                o_data <= {dhi, dlo};
            end
            o_wr <= cmd_done && cksum_ok;
        end
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: byte-level event model of the UART command receiver, compared every cycle
module tb_uart_cmd_rx;
    localparam int CPB = 104;

    logic        clk = 1'b0, reset = 1'b1, rx = 1'b1;
    logic [7:0]  o_byte, o_addr;
    logic [15:0] o_data;
    logic        o_byte_valid, o_frame_err, o_wr, o_cksum_err;

    int checks = 0, errors = 0;
    int n_bv = 0, n_fe = 0, n_wr = 0, n_ck = 0;
    int b0, f0, w0, c0;
    bit mon_on = 1'b0;

    logic [31:0] evq[$];
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_data = 16'h0000;
    int          ppos = 0;
    logic [7:0]  pa = 8'h00, ph = 8'h00, pl = 8'h00;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .o_byte(o_byte), .o_byte_valid(o_byte_valid), .o_frame_err(o_frame_err),
        .o_addr(o_addr), .o_data(o_data), .o_wr(o_wr), .o_cksum_err(o_cksum_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input logic [7:0] kind, input logic [23:0] pay, input string name);
        logic [31:0] e;
        if (evq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got pulse %h expected no pulse", name, {kind, pay});
        end else begin
            e = evq.pop_front();
            chk(name, {kind, pay}, e);
            if (e[31:24] == 8'd3) {m_addr, m_data} = e[23:0];
        end
    endtask

    // every observed pulse must be the next expected event; held registers must match the model
    always @(negedge clk) begin
        if (!reset && mon_on) begin
            if (o_byte_valid) begin n_bv++; expect_evt(8'd1, {16'h0, o_byte}, "byte_valid"); end
            if (o_frame_err) begin n_fe++; expect_evt(8'd2, 24'h0, "frame_err"); end
            if (o_wr) begin n_wr++; expect_evt(8'd3, {o_addr, o_data}, "wr"); end
            if (o_cksum_err) begin n_ck++; expect_evt(8'd4, 24'h0, "cksum_err"); end
            chk("addr_data_hold", {8'h0, o_addr, o_data}, {8'h0, m_addr, m_data});
        end
    end

    task automatic model_byte(input logic [7:0] b);
        evq.push_back({8'd1, 16'h0, b});
        case (ppos)
            0: ppos = (b == 8'hA5) ? 1 : 0;
            1: begin pa = b; ppos = 2; end
            2: begin ph = b; ppos = 3; end
            3: begin pl = b; ppos = 4; end
            default: begin
                if (b == (pa ^ ph ^ pl)) evq.push_back({8'd3, pa, ph, pl});
                else evq.push_back({8'd4, 24'h0});
                ppos = 0;
            end
        endcase
    endtask

    task automatic bits(input logic v, input int n);
        rx = v;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int gap = 2, input int stop_low = 0);
        if (gap >= 10) ppos = 0;
        if (stop_low > 0) begin
            evq.push_back({8'd2, 24'h0});
            ppos = 0;
        end else model_byte(b);
        bits(1'b1, gap);
        bits(1'b0, 1);
        for (int i = 0; i < 8; i++) bits(b[i], 1);
        if (stop_low > 0) bits(1'b0, stop_low);
        bits(1'b1, 1);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] ck, input int gap);
        send(8'hA5, gap);
        send(a, gap);
        send(h, gap);
        send(l, gap);
        send(ck, gap);
    endtask

    task automatic quiesce(input string name);
        bits(1'b1, 21);
        ppos = 0;
        chk({name, "_drained"}, evq.size(), 0);
    endtask

    task automatic snap();
        b0 = n_bv; f0 = n_fe; w0 = n_wr; c0 = n_ck;
    endtask

    initial begin
        logic [7:0] cb[5];
        int g, fe_pos, lg_pos;
        repeat (5) @(negedge clk);
        chk("reset_byte", {24'h0, o_byte}, 32'h0);
        chk("reset_addr_data", {8'h0, o_addr, o_data}, 32'h0);
        chk("reset_pulses", {28'h0, o_byte_valid, o_frame_err, o_wr, o_cksum_err}, 32'h0);
        reset = 1'b0;
        mon_on = 1'b1;
        bits(1'b1, 2);

        snap();
        send(8'h55);
        quiesce("t55");
        chk("t55_valid_count", 32'(n_bv - b0), 1);
        chk("t55_byte", {24'h0, o_byte}, 32'h55);
        chk("t55_frame_err_count", 32'(n_fe - f0), 0);

        snap();
        send_cmd(8'h01, 8'h00, 8'h96, 8'h97, 0);
        quiesce("cmd");
        chk("cmd_valid_count", 32'(n_bv - b0), 5);
        chk("cmd_wr_count", 32'(n_wr - w0), 1);
        chk("cmd_addr", {24'h0, o_addr}, 32'h01);
        chk("cmd_data", {16'h0, o_data}, 32'h0096);

        snap();
        send_cmd(8'h02, 8'h00, 8'h0A, 8'h00, 1);
        quiesce("ck");
        chk("ck_err_count", 32'(n_ck - c0), 1);
        chk("ck_wr_count", 32'(n_wr - w0), 0);
        chk("ck_addr_data_kept", {8'h0, o_addr, o_data}, 32'h0001_0096);

        snap();
        send(8'h3C, 2, 3);
        send_cmd(8'h01, 8'h00, 8'h4B, 8'h4A, 0);
        quiesce("fe");
        chk("fe_count", 32'(n_fe - f0), 1);
        chk("fe_valid_count", 32'(n_bv - b0), 5);
        chk("fe_wr_count", 32'(n_wr - w0), 1);
        chk("fe_data", {16'h0, o_data}, 32'h004B);

        snap();
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_no_pulses", 32'((n_bv - b0) + (n_fe - f0) + (n_wr - w0) + (n_ck - c0)), 0);
        send(8'hA5);
        send(8'h01);
        send(8'h00, 21);
        send(8'h96);
        send(8'h97);
        quiesce("tmo");
        chk("tmo_valid_count", 32'(n_bv - b0), 5);
        chk("tmo_wr_count", 32'(n_wr - w0), 0);

        send(8'hA5);
        bits(1'b1, 2);
        bits(1'b0, 1);
        bits(1'b1, 1);
        bits(1'b0, 1);
        bits(1'b0, 1);
        reset = 1'b1;
        ppos = 0;
        m_addr = 8'h00;
        m_data = 16'h0000;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_byte", {24'h0, o_byte}, 32'h0);
        chk("rst_mid_addr_data", {8'h0, o_addr, o_data}, 32'h0);
        chk("rst_mid_pulses", {28'h0, o_byte_valid, o_frame_err, o_wr, o_cksum_err}, 32'h0);
        chk("rst_mid_queue", evq.size(), 0);
        reset = 1'b0;
        bits(1'b1, 3);
        snap();
        send_cmd(8'h10, 8'h12, 8'h34, 8'h36, 0);
        quiesce("post_rst");
        chk("post_rst_wr_count", 32'(n_wr - w0), 1);
        chk("post_rst_addr_data", {8'h0, o_addr, o_data}, 32'h0010_1234);

        for (int it = 0; it < 4; it++) begin
            if ($urandom_range(0, 2) == 0) send(8'($urandom), 1);
            cb[0] = 8'hA5;
            cb[1] = 8'($urandom);
            cb[2] = 8'($urandom);
            cb[3] = 8'($urandom);
            cb[4] = cb[1] ^ cb[2] ^ cb[3];
            if ($urandom_range(0, 3) == 0) cb[4] = cb[4] ^ 8'(1 << $urandom_range(0, 7));
            fe_pos = $urandom_range(0, 9);
            lg_pos = $urandom_range(1, 12);
            for (int j = 0; j < 5; j++) begin
                g = $urandom_range(0, 2);
                g = (g == 2) ? 3 : g;
                if (j == lg_pos) g = 21;
                send(cb[j], g, (j == fe_pos) ? $urandom_range(1, 2) : 0);
            end
            bits(1'b1, 2);
        end
        quiesce("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
